// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between NUM_REQ byte producers.
// Grants a pending requester, pulses the active-low start strobe, then follows the
// transmitter's busy signal to detect frame completion (or a start timeout).
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       CLK_50M,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  input  logic                       tx_busy,
  output logic                       tx_start_flag,
  output logic [7:0]                 tx_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned IdxW = IdW + 1;
  localparam logic [IdW-1:0] LastInit   = IdW'(NUM_REQ - 1);
  localparam logic [7:0]     TimeoutVal = 8'(TIMEOUT);
  // Gap counter counts down to zero, so it is loaded one short of the gap length
  localparam logic [7:0]     GapLoad    = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitOn,
    StWaitOff,
    StGap
  } state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       last_q, last_d;
  logic [IdW-1:0]       grant_q, grant_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 flag_q, flag_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 found;
  logic [IdW-1:0]       winner;
  logic [IdxW-1:0]      rr_idx;
  logic [7:0]           win_byte;

  // Round-robin search starting just after the last grant, wrapping at NUM_REQ
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    rr_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_idx = {1'b0, last_q} + IdxW'(k);
      if (rr_idx >= IdxW'(NUM_REQ)) begin
        rr_idx = rr_idx - IdxW'(NUM_REQ);
      end
      if (!found && req[rr_idx[IdW-1:0]]) begin
        found  = 1'b1;
        winner = rr_idx[IdW-1:0];
      end
    end
  end

  // Byte of the winning requester
  always_comb begin
    win_byte = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdW'(i) == winner) begin
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    flag_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d        = winner;
          last_d         = winner;
          data_d         = win_byte;
          ack_d[winner]  = 1'b1;
          // Strobe goes low together with entry into START
          flag_d         = 1'b0;
          state_d        = StStart;
        end
      end
      StStart: begin
        cnt_d   = 8'd0;
        state_d = StWaitOn;
      end
      StWaitOn: begin
        if (tx_busy) begin
          state_d = StWaitOff;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutVal) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWaitOff: begin
        if (!tx_busy) begin
          done_d = 1'b1;
          if (GAP_CYC == 0) begin
            state_d = StIdle;
          end else begin
            cnt_d   = GapLoad;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; the strobe resets high so no spurious frame is launched
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      last_q  <= LastInit;
      grant_q <= '0;
      data_q  <= 8'h00;
      cnt_q   <= 8'd0;
      ack_q   <= '0;
      flag_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ack       = ack_q;
  assign tx_start_flag = flag_q;
  assign tx_data       = data_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural UART transmitter model plus a round-robin
// reference model drive randomized producers and check grants, strobes, data and timing.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int unsigned NumReq   = 4;
  localparam int unsigned GapCyc   = 2;
  localparam int unsigned Timeout  = 15;
  localparam int unsigned IdW      = $clog2(NumReq);
  localparam int          BitCyc   = 2;
  localparam int          TxLat    = 3;
  localparam int          FrameCyc = 10 * BitCyc;

  logic                  CLK_50M = 1'b0;
  logic                  RST_N   = 1'b0;
  logic [NumReq-1:0]     req     = '0;
  logic [8*NumReq-1:0]   req_data = '0;
  logic [NumReq-1:0]     req_ack;
  logic                  tx_busy;
  logic                  tx_start_flag;
  logic [7:0]            tx_data;
  logic [IdW-1:0]        grant_id;
  logic                  busy;
  logic                  done;
  logic                  err;

  int vectors     = 0;
  int miscompares = 0;
  int model_last  = NumReq - 1;

  bit   tx_model_en = 1'b1;
  bit   log_en      = 1'b0;
  bit   line_log[$];
  logic uart_line;

  uart_tx_arbiter #(
    .NUM_REQ (NumReq),
    .GAP_CYC (GapCyc),
    .TIMEOUT (Timeout)
  ) dut (
    .CLK_50M       (CLK_50M),
    .RST_N         (RST_N),
    .req           (req),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .tx_busy       (tx_busy),
    .tx_start_flag (tx_start_flag),
    .tx_data       (tx_data),
    .grant_id      (grant_id),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #10 CLK_50M = ~CLK_50M;

  // Reference rule: first requester after 'last', wrapping around
  function automatic int rr_pick(input logic [NumReq-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= NumReq; k++) begin
      idx = (last + k) % NumReq;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // UART transmitter model: falling strobe -> busy TxLat cycles later for a 10-bit frame.
  // A strobe arriving while a frame is in flight is ignored, as the real transmitter does.
  initial begin
    int         el;
    int         b;
    bit         act;
    logic [7:0] byte_q;
    logic       flag_prev;
    tx_busy   = 1'b0;
    uart_line = 1'b1;
    act       = 1'b0;
    el        = 0;
    flag_prev = 1'b1;
    byte_q    = 8'h00;
    forever begin
      @(posedge CLK_50M);
      #1;
      if (act) begin
        el++;
        if (el >= TxLat && el < TxLat + FrameCyc) begin
          b       = (el - TxLat) / BitCyc;
          tx_busy = 1'b1;
          if (b == 0) uart_line = 1'b0;
          else if (b == 9) uart_line = 1'b1;
          else uart_line = byte_q[3'(b - 1)];
        end else if (el >= TxLat + FrameCyc) begin
          tx_busy   = 1'b0;
          uart_line = 1'b1;
          act       = 1'b0;
        end
      end else if (tx_model_en && flag_prev && !tx_start_flag) begin
        act    = 1'b1;
        el     = 0;
        byte_q = tx_data;
      end
      flag_prev = tx_start_flag;
      if (log_en) line_log.push_back(uart_line);
    end
  end

  task automatic randomize_data();
    for (int i = 0; i < NumReq; i++) req_data[8*i +: 8] = 8'($urandom);
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    req   = '0;
    repeat (3) @(negedge CLK_50M);
    RST_N      = 1'b1;
    model_last = NumReq - 1;
  endtask

  // Waits (bounded) until arbiter and transmitter are both quiet
  task automatic settle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge CLK_50M);
      if (!busy && !tx_busy) ok = 1'b1;
    end
    @(negedge CLK_50M);
  endtask

  task automatic test_reset();
    logic [NumReq+IdW+11:0] obs, expv;
    RST_N = 1'b0;
    req   = '0;
    randomize_data();
    expv = {1'b1, 1'b0, {NumReq{1'b0}}, {IdW{1'b0}}, 8'h00, 2'b00};
    repeat (2) @(negedge CLK_50M);
    obs = {tx_start_flag, busy, req_ack, grant_id, tx_data, done, err};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL reset_values: got %b, expected %b", obs, expv);
    end
    RST_N      = 1'b1;
    model_last = NumReq - 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK_50M);
      vectors++;
      if (tx_start_flag !== 1'b1 || busy !== 1'b0 || tx_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: flag=%b busy=%b tx_busy=%b, expected 1 0 0",
                 c, tx_start_flag, busy, tx_busy);
      end
    end
  endtask

  task automatic test_single();
    int               exp_w, acks, lows, data_bad, i0;
    bit               in_frame, got_done, ok, stop_ok;
    logic [7:0]       dec;
    logic [NumReq-1:0] oh;
    randomize_data();
    req_data[8*2 +: 8] = 8'h55;
    req    = '0;
    req[2] = 1'b1;
    line_log.delete();
    log_en   = 1'b1;
    exp_w    = rr_pick(req, model_last);
    acks     = 0;
    lows     = 0;
    data_bad = 0;
    in_frame = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge CLK_50M);
      if (!tx_start_flag) lows++;
      if (req_ack != '0) begin
        acks++;
        oh        = '0;
        oh[exp_w] = 1'b1;
        vectors++;
        if (req_ack !== oh || grant_id !== IdW'(exp_w)) begin
          miscompares++;
          $display("FAIL single_grant: ack=%b grant=%0d, expected ack=%b grant=%0d",
                   req_ack, grant_id, oh, exp_w);
        end
        model_last = exp_w;
        req        = '0;
        in_frame   = 1'b1;
      end
      if (in_frame && tx_data !== 8'h55) data_bad++;
      if (done) got_done = 1'b1;
    end
    log_en = 1'b0;
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL single_done: done not seen, expected within 300 cycles");
    end
    vectors++;
    if (acks !== 1) begin
      miscompares++;
      $display("FAIL single_ack_count: got %0d, expected 1", acks);
    end
    vectors++;
    if (lows !== 1) begin
      miscompares++;
      $display("FAIL single_strobe_width: low for %0d cycles, expected 1", lows);
    end
    vectors++;
    if (data_bad !== 0) begin
      miscompares++;
      $display("FAIL single_data_hold: %0d cycles with tx_data!=55, expected 0", data_bad);
    end
    // Decode the serial line from the first start bit, sampling mid-bit
    i0 = -1;
    for (int i = 0; i < line_log.size(); i++) begin
      if (i0 < 0 && line_log[i] == 1'b0) i0 = i;
    end
    dec     = 8'hxx;
    stop_ok = 1'b0;
    if (i0 >= 0 && i0 + 9 * BitCyc + BitCyc / 2 < line_log.size()) begin
      for (int k = 0; k < 8; k++) dec[k] = line_log[i0 + BitCyc * (1 + k) + BitCyc / 2];
      stop_ok = line_log[i0 + 9 * BitCyc + BitCyc / 2];
    end
    vectors++;
    if (dec !== 8'h55 || !stop_ok) begin
      miscompares++;
      $display("FAIL single_line: byte %h stop %b, expected 55 stop 1", dec, stop_ok);
    end
    settle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_settle: arbiter still busy, expected idle");
    end
  endtask

  task automatic test_round_robin();
    int               exp_w, frames, dones, cyc, last_done, gap_bad;
    bit               ok;
    logic [NumReq-1:0] oh;
    apply_reset();
    randomize_data();
    req       = '1;
    frames    = 0;
    dones     = 0;
    cyc       = 0;
    last_done = -1;
    gap_bad   = 0;
    for (int c = 0; c < 2000 && dones < 8; c++) begin
      @(negedge CLK_50M);
      cyc++;
      if (req_ack != '0) begin
        exp_w     = rr_pick(req, model_last);
        oh        = '0;
        oh[exp_w] = 1'b1;
        vectors++;
        if (req_ack !== oh || grant_id !== IdW'(exp_w) ||
            tx_data !== req_data[8*exp_w +: 8]) begin
          miscompares++;
          $display("FAIL rr_grant %0d: ack=%b grant=%0d data=%h, expected ack=%b grant=%0d data=%h",
                   frames, req_ack, grant_id, tx_data, oh, exp_w, req_data[8*exp_w +: 8]);
        end
        if (last_done >= 0) begin
          vectors++;
          if (cyc - last_done !== int'(GapCyc) + 1) begin
            miscompares++;
            $display("FAIL rr_gap %0d: done-to-ack %0d cycles, expected %0d",
                     frames, cyc - last_done, GapCyc + 1);
          end
        end
        model_last = exp_w;
        req_data[8*exp_w +: 8] = 8'($urandom);
        frames++;
        if (frames == 8) req = '0;
      end
      if (last_done >= 0 && cyc - last_done <= int'(GapCyc) && !tx_start_flag) gap_bad++;
      if (done) begin
        dones++;
        last_done = cyc;
      end
    end
    vectors++;
    if (dones !== 8 || frames !== 8 || gap_bad !== 0) begin
      miscompares++;
      $display("FAIL rr_totals: dones=%0d frames=%0d gap_strobes=%0d, expected 8 8 0",
               dones, frames, gap_bad);
    end
    settle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rr_settle: arbiter still busy, expected idle");
    end
  endtask

  task automatic test_timeout();
    int exp_w, acks, errs, dones, cyc, s_cyc;
    int got_g[$];
    bit ok;
    tx_model_en = 1'b0;
    randomize_data();
    req    = '0;
    req[1] = 1'b1;
    req[3] = 1'b1;
    acks   = 0;
    errs   = 0;
    dones  = 0;
    cyc    = 0;
    s_cyc  = -1000;
    for (int c = 0; c < 500 && errs < 3; c++) begin
      @(negedge CLK_50M);
      cyc++;
      if (req_ack != '0) begin
        exp_w = rr_pick(req, model_last);
        got_g.push_back(int'(grant_id));
        vectors++;
        if (grant_id !== IdW'(exp_w)) begin
          miscompares++;
          $display("FAIL to_grant %0d: grant=%0d, expected %0d", acks, grant_id, exp_w);
        end
        model_last = exp_w;
        acks++;
        if (acks == 3) req = '0;
      end
      if (!tx_start_flag) s_cyc = cyc;
      if (err) begin
        errs++;
        vectors++;
        if (cyc - s_cyc !== int'(Timeout) + 1) begin
          miscompares++;
          $display("FAIL to_latency %0d: err %0d cycles after strobe, expected %0d",
                   errs, cyc - s_cyc, Timeout + 1);
        end
      end
      if (done) dones++;
    end
    vectors++;
    if (errs !== 3 || dones !== 0 || acks !== 3) begin
      miscompares++;
      $display("FAIL to_totals: errs=%0d dones=%0d acks=%0d, expected 3 0 3", errs, dones, acks);
    end
    vectors++;
    if (got_g.size() != 3 || got_g[0] !== 1 || got_g[1] !== 3 || got_g[2] !== 1) begin
      miscompares++;
      $display("FAIL to_order: got %p, expected '{1,3,1}", got_g);
    end
    settle(ok);
    tx_model_en = 1'b1;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL to_settle: arbiter still busy, expected idle");
    end
  endtask

  task automatic test_back_to_back();
    int exp_w, acks, ack3, dones;
    int got_g[$];
    bit pulsed, ok;
    randomize_data();
    req    = '0;
    req[0] = 1'b1;
    acks   = 0;
    ack3   = 0;
    dones  = 0;
    pulsed = 1'b0;
    for (int c = 0; c < 600 && dones < 3; c++) begin
      @(negedge CLK_50M);
      if (req_ack != '0) begin
        exp_w = rr_pick(req, model_last);
        got_g.push_back(int'(grant_id));
        vectors++;
        if (grant_id !== IdW'(exp_w) || tx_data !== req_data[8*exp_w +: 8]) begin
          miscompares++;
          $display("FAIL b2b_grant %0d: grant=%0d data=%h, expected %0d data=%h",
                   acks, grant_id, tx_data, exp_w, req_data[8*exp_w +: 8]);
        end
        if (req_ack[3]) ack3++;
        model_last = exp_w;
        req_data[8*exp_w +: 8] = 8'($urandom);
        if (exp_w == 3) req[3] = 1'b0;
        acks++;
        if (acks == 3) req = '0;
      end
      // Raise req[3] once while the first frame is on the line
      if (tx_busy && acks == 1 && !pulsed) begin
        req[3] = 1'b1;
        pulsed = 1'b1;
      end
      if (done) dones++;
    end
    vectors++;
    if (ack3 !== 1 || acks !== 3 || dones !== 3) begin
      miscompares++;
      $display("FAIL b2b_totals: ack3=%0d acks=%0d dones=%0d, expected 1 3 3", ack3, acks, dones);
    end
    vectors++;
    if (got_g.size() != 3 || got_g[0] !== 0 || got_g[1] !== 3 || got_g[2] !== 0) begin
      miscompares++;
      $display("FAIL b2b_order: got %p, expected '{0,3,0}", got_g);
    end
    settle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_settle: arbiter still busy, expected idle");
    end
  endtask

  task automatic test_random();
    int               exp_w, acks;
    bit               ok;
    logic [NumReq-1:0] oh;
    randomize_data();
    req  = NumReq'($urandom_range(1, (1 << NumReq) - 1));
    acks = 0;
    for (int c = 0; c < 3000 && acks < 16; c++) begin
      @(negedge CLK_50M);
      if (req_ack != '0) begin
        exp_w     = rr_pick(req, model_last);
        oh        = '0;
        oh[exp_w] = 1'b1;
        vectors++;
        if (req_ack !== oh || grant_id !== IdW'(exp_w) ||
            tx_data !== req_data[8*exp_w +: 8]) begin
          miscompares++;
          $display("FAIL rand_grant %0d: req=%b ack=%b grant=%0d data=%h, expected ack=%b grant=%0d data=%h",
                   acks, req, req_ack, grant_id, tx_data, oh, exp_w, req_data[8*exp_w +: 8]);
        end
        model_last = exp_w;
        acks++;
        randomize_data();
        req = (acks == 16) ? '0 : NumReq'($urandom_range(1, (1 << NumReq) - 1));
      end
    end
    vectors++;
    if (acks !== 16) begin
      miscompares++;
      $display("FAIL rand_count: %0d grants, expected 16", acks);
    end
    settle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rand_settle: arbiter still busy, expected idle");
    end
  endtask

  task automatic test_reset_mid();
    int                     exp_w, run;
    bit                     got_ack, hit, ok;
    logic [NumReq+IdW+11:0] obs, expv;
    randomize_data();
    req     = '0;
    req[2]  = 1'b1;
    exp_w   = rr_pick(req, model_last);
    run     = 0;
    got_ack = 1'b0;
    hit     = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge CLK_50M);
      if (req_ack != '0) begin
        vectors++;
        if (grant_id !== IdW'(exp_w)) begin
          miscompares++;
          $display("FAIL rst_pre_grant: grant=%0d, expected %0d", grant_id, exp_w);
        end
        model_last = exp_w;
        req        = '0;
        got_ack    = 1'b1;
      end
      if (got_ack && tx_busy) run++;
      if (run == 2) hit = 1'b1;
    end
    vectors++;
    if (!hit || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_reach_wait_off: reached=%b busy=%b, expected 1 1", hit, busy);
    end
    RST_N = 1'b0;
    #1;
    expv = {1'b1, 1'b0, {NumReq{1'b0}}, {IdW{1'b0}}, 8'h00, 2'b00};
    obs  = {tx_start_flag, busy, req_ack, grant_id, tx_data, done, err};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL rst_async_values: got %b, expected %b", obs, expv);
    end
    @(negedge CLK_50M);
    RST_N      = 1'b1;
    model_last = NumReq - 1;
    randomize_data();
    req     = '1;
    exp_w   = rr_pick(req, model_last);
    got_ack = 1'b0;
    for (int c = 0; c < 50 && !got_ack; c++) begin
      @(negedge CLK_50M);
      if (req_ack != '0) begin
        got_ack = 1'b1;
        vectors++;
        if (grant_id !== IdW'(exp_w) || tx_data !== req_data[8*exp_w +: 8]) begin
          miscompares++;
          $display("FAIL rst_first_grant: grant=%0d data=%h, expected %0d data=%h",
                   grant_id, tx_data, exp_w, req_data[8*exp_w +: 8]);
        end
        model_last = exp_w;
        req        = '0;
      end
    end
    req = '0;
    vectors++;
    if (!got_ack) begin
      miscompares++;
      $display("FAIL rst_no_grant: no ack after reset release, expected one");
    end
    settle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rst_settle: arbiter still busy, expected idle");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
